fp_issue_ctrl: RTL and testbench

Sequencer that sits directly upstream of the 64-bit FP arithmetic units (add/sub/mul/div) and also performs their writeback.
- Fetches 32-bit instructions from instruction memory.
- Reads both 64-bit operands from data memory through one synchronous read port.
- Drives the operands, op select and enable to the FP unit, then writes the result back to data memory.
- Runs one instruction at a time from start until HALT.

---
 rtl/fp_pkg.sv | 62 ++++++
 rtl/fp_issue_ctrl.sv | 127 ++++++++++++
 tb/tb_fp_issue_ctrl.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the FP issue/writeback sequencer:
// opcodes, FP unit select codes, instruction layout and FSM states.
package fp_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_DIV  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] FPU_ADD = 2'b00;
  localparam logic [1:0] FPU_SUB = 2'b01;
  localparam logic [1:0] FPU_MUL = 2'b10;
  localparam logic [1:0] FPU_DIV = 2'b11;

  localparam int OP_LSB  = 28;
  localparam int RD_LSB  = 20;
  localparam int RA_LSB  = 12;
  localparam int RB_LSB  = 4;
  localparam int FIELD_W = 8;

  typedef struct packed {
    logic [3:0]         op;
    logic [FIELD_W-1:0] rd;
    logic [FIELD_W-1:0] ra;
    logic [FIELD_W-1:0] rb;
    logic [3:0]         rsvd;
  } instr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_READ_A,
    S_READ_B,
    S_EXEC,
    S_WRITE,
    S_HALTED
  } state_t;

  function automatic logic is_arith(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return is_arith(op) || op == OP_NOP || op == OP_HALT;
  endfunction

  function automatic logic [1:0] fpu_sel(input logic [3:0] op);
    logic [1:0] sel;
    sel = FPU_ADD;
    unique case (op)
      OP_SUB:  sel = FPU_SUB;
      OP_MUL:  sel = FPU_MUL;
      OP_DIV:  sel = FPU_DIV;
      default: sel = FPU_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/fp_issue_ctrl.sv
// Single-issue sequencer for the 64-bit FP units: fetch, decode,
// two operand reads, timed execute, then writeback to data memory.
module fp_issue_ctrl
  import fp_pkg::*;
#(
  parameter int IADDR_W     = 8,
  parameter int DADDR_W     = 8,
  parameter int EXEC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic [15:0]        retired,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [DADDR_W-1:0] dmem_raddr,
  input  logic [63:0]        dmem_rdata,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_waddr,
  output logic [63:0]        dmem_wdata,
  output logic [63:0]        fpu_a,
  output logic [63:0]        fpu_b,
  output logic [1:0]         fpu_op,
  output logic               fpu_en,
  input  logic [63:0]        fpu_result
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_CYCLES - 1);

  state_t             state, state_d;
  logic [IADDR_W-1:0] pc;
  logic [CW-1:0]      cnt;
  instr_t             ir;
  instr_t             instr_q;
  logic               exec_last;
  logic               unused_instr;

  assign ir        = instr_t'(imem_rdata);
  assign exec_last = (cnt == CNT_LAST);

  // Only rd/rb/op of the held instruction are consumed after decode.
  assign unused_instr = ^instr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_arith(ir.op):   state_d = S_READ_A;
          ir.op == OP_HALT:  state_d = S_HALTED;
          default:           state_d = S_FETCH;
        endcase
      end
      S_READ_A: state_d = S_READ_B;
      S_READ_B: state_d = S_EXEC;
      S_EXEC:   if (exec_last) state_d = S_WRITE;
      S_WRITE:  state_d = S_FETCH;
      S_HALTED: if (start) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  assign busy       = !(state inside {S_IDLE, S_HALTED});
  assign halted     = (state == S_HALTED);
  assign fpu_en     = (state == S_EXEC);
  assign dmem_we    = (state == S_WRITE);
  assign imem_addr  = pc;
  assign dmem_waddr = instr_q.rd[DADDR_W-1:0];

  // ra must go out during decode so its data lands in READ_A.
  assign dmem_raddr = (state == S_DECODE) ? ir.ra[DADDR_W-1:0]
                                          : instr_q.rb[DADDR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= '0;
      cnt        <= '0;
      instr_q    <= '0;
      illegal    <= 1'b0;
      retired    <= '0;
      fpu_a      <= '0;
      fpu_b      <= '0;
      fpu_op     <= FPU_ADD;
      dmem_wdata <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_HALTED: begin
          if (start) pc <= '0;
        end
        S_DECODE: begin
          instr_q <= ir;
          if (!is_arith(ir.op) && ir.op != OP_HALT)
            pc <= pc + 1'b1;
          if (!is_legal(ir.op))
            illegal <= 1'b1;
        end
        S_READ_A: fpu_a <= dmem_rdata;
        S_READ_B: begin
          fpu_b  <= dmem_rdata;
          fpu_op <= fpu_sel(instr_q.op);
          cnt    <= '0;
        end
        S_EXEC: begin
          cnt <= cnt + 1'b1;
          if (exec_last) dmem_wdata <= fpu_result;
        end
        S_WRITE: begin
          pc      <= pc + 1'b1;
          retired <= retired + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Bench for fp_issue_ctrl: three instances (default, EXEC_CYCLES=3,
// IADDR_W=2) with behavioural memories, an FP model and a write scoreboard.
module tb_fp_issue_ctrl;

  localparam logic [63:0] F1 = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] F2 = 64'h4000_0000_0000_0000;
  localparam logic [63:0] F3 = 64'h4008_0000_0000_0000;
  localparam logic [63:0] F4 = 64'h4010_0000_0000_0000;
  localparam logic [63:0] F6 = 64'h4018_0000_0000_0000;

  typedef struct {
    logic [7:0]  a;
    logic [63:0] d;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  wr_t        exp_q[$];
  wr_t        obs_q[$];
  logic [7:0] ia_log[$];
  int         halt_at;
  int         en_cnt;
  int         idle_busy;

  function automatic logic [63:0] fpu(input logic [1:0] op,
                                      input logic [63:0] a,
                                      input logic [63:0] b);
    real x;
    real y;
    real r;
    x = $bitstoreal(a);
    y = $bitstoreal(b);
    case (op)
      2'd0:    r = x + y;
      2'd1:    r = x - y;
      2'd2:    r = x * y;
      default: r = x / y;
    endcase
    return $realtobits(r);
  endfunction

  function automatic logic [31:0] ins(input logic [3:0] op,
                                      input logic [7:0] rd,
                                      input logic [7:0] ra,
                                      input logic [7:0] rb);
    return {op, rd, ra, rb, 4'h0};
  endfunction

  // instance 0: default parameters
  logic        start0, busy0, halted0, illegal0, dwe0, fen0;
  logic [15:0] ret0;
  logic [7:0]  ia0, dra0, dwa0;
  logic [31:0] ird0;
  logic [63:0] drd0, dwd0, fa0, fb0, fres0;
  logic [1:0]  fop0;
  logic [31:0] imem0 [256];
  logic [63:0] dmem0 [256];

  always @(posedge clk) begin
    ird0 <= imem0[ia0];
    drd0 <= dmem0[dra0];
  end
  always_comb fres0 = fpu(fop0, fa0, fb0);

  fp_issue_ctrl u_dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .busy(busy0), .halted(halted0), .illegal(illegal0),
    .retired(ret0), .imem_addr(ia0), .imem_rdata(ird0),
    .dmem_raddr(dra0), .dmem_rdata(drd0), .dmem_we(dwe0),
    .dmem_waddr(dwa0), .dmem_wdata(dwd0), .fpu_a(fa0),
    .fpu_b(fb0), .fpu_op(fop0), .fpu_en(fen0),
    .fpu_result(fres0)
  );

  // instance 1: three execute cycles
  logic        start1, busy1, halted1, illegal1, dwe1, fen1;
  logic [15:0] ret1;
  logic [7:0]  ia1, dra1, dwa1;
  logic [31:0] ird1;
  logic [63:0] drd1, dwd1, fa1, fb1, fres1;
  logic [1:0]  fop1;
  logic [31:0] imem1 [256];
  logic [63:0] dmem1 [256];

  always @(posedge clk) begin
    ird1 <= imem1[ia1];
    drd1 <= dmem1[dra1];
  end
  always_comb fres1 = fpu(fop1, fa1, fb1);

  fp_issue_ctrl #(.EXEC_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .busy(busy1), .halted(halted1), .illegal(illegal1),
    .retired(ret1), .imem_addr(ia1), .imem_rdata(ird1),
    .dmem_raddr(dra1), .dmem_rdata(drd1), .dmem_we(dwe1),
    .dmem_waddr(dwa1), .dmem_wdata(dwd1), .fpu_a(fa1),
    .fpu_b(fb1), .fpu_op(fop1), .fpu_en(fen1),
    .fpu_result(fres1)
  );

  // instance 2: 2-bit PC
  logic        start2, busy2, halted2, illegal2, dwe2, fen2;
  logic [15:0] ret2;
  logic [1:0]  ia2;
  logic [7:0]  dra2, dwa2;
  logic [31:0] ird2;
  logic [63:0] dwd2, fa2, fb2;
  logic [1:0]  fop2;
  logic [31:0] imem2 [4];

  always @(posedge clk) ird2 <= imem2[ia2];

  fp_issue_ctrl #(.IADDR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .busy(busy2), .halted(halted2), .illegal(illegal2),
    .retired(ret2), .imem_addr(ia2), .imem_rdata(ird2),
    .dmem_raddr(dra2), .dmem_rdata(64'd0), .dmem_we(dwe2),
    .dmem_waddr(dwa2), .dmem_wdata(dwd2), .fpu_a(fa2),
    .fpu_b(fb2), .fpu_op(fop2), .fpu_en(fen2),
    .fpu_result(64'd0)
  );

  task automatic do_reset();
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Pulse start0 and record writes, PC trace and flags until HALTED.
  task automatic run0(input int bound);
    obs_q.delete();
    ia_log.delete();
    halt_at   = -1;
    en_cnt    = 0;
    idle_busy = 0;
    start0    = 1'b1;
    for (int k = 1; k <= bound && halt_at < 0; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      ia_log.push_back(ia0);
      if (fen0) en_cnt++;
      if (dwe0) begin
        dmem0[dwa0] = dwd0;
        obs_q.push_back('{a: dwa0, d: dwd0, cyc: k});
      end
      if (halted0) halt_at = k;
      else if (!busy0) idle_busy++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({busy0, halted0, illegal0, dwe0, fen0} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=00000",
               {busy0, halted0, illegal0, dwe0, fen0});
    end
    total++;
    if (ret0 !== 16'd0 || ia0 !== 8'd0) begin
      bad++;
      $display("FAIL reset_cnt_pc ret=%0d pc=%0d exp=0/0", ret0, ia0);
    end
    total++;
    if ({fa0, fb0, fop0} !== 130'd0) begin
      bad++;
      $display("FAIL reset_fpu a=%h b=%h op=%0d exp=0", fa0, fb0, fop0);
    end
  endtask

  task automatic test_mul();
    wr_t e, o;
    dmem0[1] = F2;
    dmem0[2] = F3;
    dmem0[3] = 64'd0;
    imem0[0] = ins(4'h3, 8'd3, 8'd1, 8'd2);
    imem0[1] = ins(4'hF, 8'd0, 8'd0, 8'd0);
    exp_q.push_back('{a: 8'd3, d: F6, cyc: 6});
    run0(30);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL mul_nwr got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o.a !== e.a || o.d !== e.d || o.cyc != e.cyc) begin
        bad++;
        $display("FAIL mul_wr got=%0d/%h@%0d exp=%0d/%h@%0d",
                 o.a, o.d, o.cyc, e.a, e.d, e.cyc);
      end
    end
    exp_q.delete();
    total++;
    if (halt_at != 9 || ret0 !== 16'd1 || en_cnt != 1) begin
      bad++;
      $display("FAIL mul_end halt@%0d ret=%0d en=%0d exp=9/1/1",
               halt_at, ret0, en_cnt);
    end
    total++;
    if (fa0 !== F2 || fb0 !== F3 || fop0 !== 2'b10) begin
      bad++;
      $display("FAIL mul_ops a=%h b=%h op=%0d exp=%h/%h/2",
               fa0, fb0, fop0, F2, F3);
    end
  endtask

  task automatic test_nop_add();
    wr_t e, o;
    dmem0[4] = 64'd0;
    imem0[0] = ins(4'h0, 8'd0, 8'd0, 8'd0);
    imem0[1] = ins(4'h0, 8'd0, 8'd0, 8'd0);
    imem0[2] = ins(4'h1, 8'd4, 8'd1, 8'd1);
    imem0[3] = ins(4'hF, 8'd0, 8'd0, 8'd0);
    exp_q.push_back('{a: 8'd4, d: F4, cyc: 10});
    run0(40);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL add_nwr got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o.a !== e.a || o.d !== e.d || o.cyc != e.cyc) begin
        bad++;
        $display("FAIL add_wr got=%0d/%h@%0d exp=%0d/%h@%0d",
                 o.a, o.d, o.cyc, e.a, e.d, e.cyc);
      end
    end
    exp_q.delete();
    total++;
    if (ia_log.size() < 5 || ia_log[0] !== 8'd0 ||
        ia_log[2] !== 8'd1 || ia_log[4] !== 8'd2) begin
      bad++;
      $display("FAIL nop_pc trace=%p exp pc 0,1,2 at k=1,3,5", ia_log);
    end
    total++;
    if (halt_at != 13 || idle_busy != 0 || ret0 !== 16'd2) begin
      bad++;
      $display("FAIL add_end halt@%0d idle=%0d ret=%0d exp=13/0/2",
               halt_at, idle_busy, ret0);
    end
  endtask

  task automatic test_illegal();
    total++;
    if (illegal0 !== 1'b0) begin
      bad++;
      $display("FAIL ill_pre got=%b exp=0", illegal0);
    end
    imem0[0] = 32'h7000_0000;
    imem0[1] = ins(4'hF, 8'd0, 8'd0, 8'd0);
    run0(20);
    total++;
    if (illegal0 !== 1'b1 || obs_q.size() != 0 || halt_at != 5) begin
      bad++;
      $display("FAIL ill_run ill=%b nwr=%0d halt@%0d exp=1/0/5",
               illegal0, obs_q.size(), halt_at);
    end
    run0(20);
    total++;
    if (illegal0 !== 1'b1 || ia_log[0] !== 8'd0 || halt_at != 5 ||
        ret0 !== 16'd2) begin
      bad++;
      $display("FAIL ill_rerun ill=%b pc0=%0d halt@%0d ret=%0d exp=1/0/5/2",
               illegal0, ia_log[0], halt_at, ret0);
    end
  endtask

  task automatic test_exec3();
    wr_t e, o;
    int en_first, en_last, h_at;
    en_first = -1;
    en_last  = -1;
    h_at     = -1;
    en_cnt   = 0;
    obs_q.delete();
    dmem1[1] = F3;
    dmem1[2] = F2;
    imem1[0] = ins(4'h2, 8'd1, 8'd1, 8'd2);
    imem1[1] = ins(4'hF, 8'd0, 8'd0, 8'd0);
    exp_q.push_back('{a: 8'd1, d: F1, cyc: 8});
    start1 = 1'b1;
    for (int k = 1; k <= 30 && h_at < 0; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (fen1) begin
        en_cnt++;
        if (en_first < 0) en_first = k;
        en_last = k;
      end
      if (dwe1) begin
        dmem1[dwa1] = dwd1;
        obs_q.push_back('{a: dwa1, d: dwd1, cyc: k});
      end
      if (halted1) h_at = k;
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL ex3_nwr got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o.a !== e.a || o.d !== e.d || o.cyc != e.cyc) begin
        bad++;
        $display("FAIL ex3_wr got=%0d/%h@%0d exp=%0d/%h@%0d",
                 o.a, o.d, o.cyc, e.a, e.d, e.cyc);
      end
    end
    exp_q.delete();
    total++;
    if (en_cnt != 3 || en_first != 5 || en_last != 7) begin
      bad++;
      $display("FAIL ex3_en cnt=%0d first=%0d last=%0d exp=3/5/7",
               en_cnt, en_first, en_last);
    end
    total++;
    if (dmem1[1] !== F1 || h_at != 11 || ret1 !== 16'd1) begin
      bad++;
      $display("FAIL ex3_end m1=%h halt@%0d ret=%0d exp=%h/11/1",
               dmem1[1], h_at, ret1, F1);
    end
  endtask

  task automatic test_reset_mid();
    wr_t e, o;
    dmem0[1] = F2;
    dmem0[2] = F3;
    dmem0[3] = 64'd0;
    imem0[0] = ins(4'h3, 8'd3, 8'd1, 8'd2);
    imem0[1] = ins(4'hF, 8'd0, 8'd0, 8'd0);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (fen0 !== 1'b1) begin
      bad++;
      $display("FAIL rmid_inexec fpu_en=%b exp=1", fen0);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({busy0, halted0, illegal0, fen0, dwe0} !== 5'b0 ||
        ret0 !== 16'd0 || ia0 !== 8'd0 ||
        {fa0, fb0, fop0} !== 130'd0) begin
      bad++;
      $display("FAIL rmid_async fl=%b ret=%0d pc=%0d a=%h op=%0d exp=0",
               {busy0, halted0, illegal0, fen0, dwe0}, ret0, ia0,
               fa0, fop0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (dwe0 !== 1'b0 || busy0 !== 1'b0) begin
        bad++;
        $display("FAIL rmid_quiet k=%0d we=%b busy=%b exp=0/0",
                 k, dwe0, busy0);
      end
    end
    exp_q.push_back('{a: 8'd3, d: F6, cyc: 6});
    run0(30);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL rmid_nwr got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o.a !== e.a || o.d !== e.d || o.cyc != e.cyc) begin
        bad++;
        $display("FAIL rmid_wr got=%0d/%h@%0d exp=%0d/%h@%0d",
                 o.a, o.d, o.cyc, e.a, e.d, e.cyc);
      end
    end
    exp_q.delete();
    total++;
    if (ret0 !== 16'd1 || halt_at != 9) begin
      bad++;
      $display("FAIL rmid_end ret=%0d halt@%0d exp=1/9", ret0, halt_at);
    end
  endtask

  task automatic test_pc_wrap();
    logic [1:0] pc_exp[$];
    logic [1:0] want;
    for (int i = 0; i < 4; i++) imem2[i] = 32'h0000_0000;
    pc_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    start2 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1 || k == 5) start2 = 1'b0;
      total++;
      if (busy2 !== 1'b1) begin
        bad++;
        $display("FAIL wrap_busy k=%0d got=%b exp=1", k, busy2);
      end
      if (k % 2 == 1) begin
        want = pc_exp.pop_front();
        total++;
        if (ia2 !== want) begin
          bad++;
          $display("FAIL wrap_pc k=%0d got=%0d exp=%0d", k, ia2, want);
        end
      end
      if (k == 4) start2 = 1'b1;
    end
    do_reset();
  endtask

  initial begin
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    test_reset();
    test_mul();
    test_nop_add();
    test_illegal();
    test_exec3();
    test_reset_mid();
    test_pc_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
